duck_flight_engine: RTL and testbench

//  Responder side of the game-control event protocol. It launches one duck per round when the 2-bit

---
 rtl/duck_flight_engine.sv | 179 +++++++++++++++++
 tb/tb_duck_flight_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duck_flight_engine.sv
// Duck flight engine: launches one duck per round, moves it on frame ticks,
// tests gun shots against it and reports hit/escape events to the round controller.
module duck_flight_engine #(
  parameter int X_MIN      = 64,
  parameter int X_MAX      = 576,
  parameter int Y_START    = 400,
  parameter int Y_GROUND   = 440,
  parameter int SPEED      = 2,
  parameter int FALL_SPEED = 4,
  parameter int HIT_R      = 16,
  parameter int FLY_FRAMES = 300
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [1:0] state,
  input  logic       shot,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  output logic [9:0] bird_x,
  output logic [9:0] bird_y,
  output logic       bird_visible,
  output logic       bird_falling,
  output logic       bird_shot,
  output logic       flew_away
);

  localparam logic [9:0]  XMIN   = 10'(X_MIN);
  localparam logic [9:0]  XMAX   = 10'(X_MAX);
  localparam logic [9:0]  YSTART = 10'(Y_START);
  localparam logic [9:0]  YGND   = 10'(Y_GROUND);
  localparam logic [9:0]  SPD    = 10'(SPEED);
  localparam logic [9:0]  FSPD   = 10'(FALL_SPEED);
  localparam logic [10:0] HITR   = 11'(HIT_R);
  localparam logic [8:0]  FLYF   = 9'(FLY_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_FLY, S_FALL, S_ESCAPE, S_WAIT
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dir_q, dir_d;
  logic [8:0]  timer_q, timer_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        vis_q, vis_d, fall_q, fall_d, shot_q, shot_d, flew_q, flew_d;
  logic [10:0] dx, dy, adx, ady;
  logic        hit, escape;

  // Differences are widened to 11 bits so the sign survives the subtraction.
  assign dx  = {1'b0, aim_x} - {1'b0, x_q};
  assign dy  = {1'b0, aim_y} - {1'b0, y_q};
  assign adx = dx[10] ? (~dx + 11'd1) : dx;
  assign ady = dy[10] ? (~dy + 11'd1) : dy;

  assign hit    = shot && (state == 2'b10) && (adx <= HITR) && (ady <= HITR);
  assign escape = (timer_q == FLYF) || (y_q <= SPD);

  always_comb begin
    fsm_d   = fsm_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    vis_d   = vis_q;
    fall_d  = fall_q;
    shot_d  = 1'b0;
    flew_d  = 1'b0;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (state == 2'b00 || state == 2'b11) begin
      fsm_d  = S_IDLE;
      vis_d  = 1'b0;
      fall_d = 1'b0;
    end else if (state == 2'b01 && fsm_q != S_LAUNCH) begin
      fsm_d  = S_LAUNCH;
      vis_d  = 1'b0;
      fall_d = 1'b0;
    end else begin
      case (fsm_q)
        S_LAUNCH: begin
          x_d     = XMIN + {1'b0, lfsr_q, 1'b0};
          y_d     = YSTART;
          dir_d   = lfsr_q[0];
          timer_d = '0;
          vis_d   = 1'b1;
          fsm_d   = S_FLY;
        end
        S_FLY: begin
          // A hit outranks a simultaneous escape; either exit freezes the position.
          if (hit) begin
            shot_d = 1'b1;
            fall_d = 1'b1;
            fsm_d  = S_FALL;
          end else if (escape) begin
            flew_d = 1'b1;
            fsm_d  = S_ESCAPE;
          end else if (frame_tick) begin
            if (dir_q) begin
              if (x_q + SPD >= XMAX) begin
                x_d   = XMAX;
                dir_d = 1'b0;
              end else begin
                x_d = x_q + SPD;
              end
            end else begin
              if (x_q <= XMIN + SPD) begin
                x_d   = XMIN;
                dir_d = 1'b1;
              end else begin
                x_d = x_q - SPD;
              end
            end
            y_d     = y_q - SPD;
            timer_d = timer_q + 9'd1;
          end
        end
        S_FALL: begin
          if (frame_tick) begin
            if (y_q + FSPD >= YGND) begin
              y_d    = YGND;
              vis_d  = 1'b0;
              fall_d = 1'b0;
              fsm_d  = S_WAIT;
            end else begin
              y_d = y_q + FSPD;
            end
          end
        end
        S_ESCAPE: begin
          if (frame_tick) begin
            if (y_q <= SPD) begin
              y_d   = '0;
              vis_d = 1'b0;
              fsm_d = S_WAIT;
            end else begin
              y_d = y_q - SPD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_q   <= S_IDLE;
      x_q     <= XMIN;
      y_q     <= YSTART;
      dir_q   <= 1'b1;
      timer_q <= '0;
      lfsr_q  <= 8'hA5;
      vis_q   <= 1'b0;
      fall_q  <= 1'b0;
      shot_q  <= 1'b0;
      flew_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      vis_q   <= vis_d;
      fall_q  <= fall_d;
      shot_q  <= shot_d;
      flew_q  <= flew_d;
    end
  end

  assign bird_x       = x_q;
  assign bird_y       = y_q;
  assign bird_visible = vis_q;
  assign bird_falling = fall_q;
  assign bird_shot    = shot_q;
  assign flew_away    = flew_q;

endmodule

// File: tb/tb_duck_flight_engine.sv
// Scoreboard bench for duck_flight_engine: a behavioural game model predicts every
// cycle's outputs and every hit/escape event; a monitor compares what the DUT shows.
module tb_duck_flight_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] state = 2'b00;
  logic       shot = 1'b0;
  logic [9:0] aim_x = '0;
  logic [9:0] aim_y = '0;
  logic [9:0] bird_x, bird_y;
  logic       bird_visible, bird_falling, bird_shot, flew_away;

  duck_flight_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .state(state), .shot(shot),
    .aim_x(aim_x), .aim_y(aim_y), .bird_x(bird_x), .bird_y(bird_y),
    .bird_visible(bird_visible), .bird_falling(bird_falling),
    .bird_shot(bird_shot), .flew_away(flew_away)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic vis, fal, sh, fl;
  } snap_t;

  typedef struct packed {
    logic sh, fl;
    logic [9:0] x, y;
  } ev_t;

  snap_t exp_q[$];
  ev_t   ev_q[$];
  int    errors = 0;
  int    checks = 0;
  int    dut_flew_cnt = 0;

  // Behavioural game model (phase names follow the game description).
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_FLY = 2, P_FALL = 3, P_ESCAPE = 4, P_WAIT = 5;
  int m_phase, m_x, m_y, m_vis, m_fal, m_sh, m_fl, m_right, m_timer, m_lfsr;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) & 255) | fb;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input bit r, input bit tk, input int st, input bit sh,
                            input int ax, input int ay);
    int cur;
    if (r) begin
      m_phase = P_IDLE; m_x = 64; m_y = 400; m_vis = 0; m_fal = 0; m_sh = 0; m_fl = 0;
      m_right = 1; m_timer = 0; m_lfsr = 'hA5;
      return;
    end
    m_sh = 0; m_fl = 0;
    cur = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    if (st == 0 || st == 3) begin
      m_phase = P_IDLE; m_vis = 0; m_fal = 0;
    end else if (st == 1 && m_phase != P_LAUNCH) begin
      m_phase = P_LAUNCH; m_vis = 0; m_fal = 0;
    end else if (m_phase == P_LAUNCH) begin
      m_x = 64 + 2 * cur; m_y = 400; m_right = cur & 1; m_timer = 0;
      m_vis = 1; m_phase = P_FLY;
    end else if (m_phase == P_FLY) begin
      if (sh && st == 2 && iabs(ax - m_x) <= 16 && iabs(ay - m_y) <= 16) begin
        m_sh = 1; m_fal = 1; m_phase = P_FALL;
      end else if (m_timer == 300 || m_y <= 2) begin
        m_fl = 1; m_phase = P_ESCAPE;
      end else if (tk) begin
        if (m_right != 0) begin
          if (m_x + 2 >= 576) begin m_x = 576; m_right = 0; end
          else m_x = m_x + 2;
        end else begin
          if (m_x <= 66) begin m_x = 64; m_right = 1; end
          else m_x = m_x - 2;
        end
        m_y = m_y - 2;
        m_timer++;
      end
    end else if (m_phase == P_FALL) begin
      if (tk) begin
        m_y = m_y + 4;
        if (m_y >= 440) begin m_y = 440; m_vis = 0; m_fal = 0; m_phase = P_WAIT; end
      end
    end else if (m_phase == P_ESCAPE) begin
      if (tk) begin
        if (m_y <= 2) begin m_y = 0; m_vis = 0; m_phase = P_WAIT; end
        else m_y = m_y - 2;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit tk, input logic [1:0] st, input bit sh,
                     input logic [9:0] ax, input logic [9:0] ay);
    snap_t s;
    ev_t   e;
    Reset = r; frame_tick = tk; state = st; shot = sh; aim_x = ax; aim_y = ay;
    model_step(r, tk, int'(st), sh, int'(ax), int'(ay));
    s.x = 10'(m_x); s.y = 10'(m_y);
    s.vis = m_vis[0]; s.fal = m_fal[0]; s.sh = m_sh[0]; s.fl = m_fl[0];
    if (m_sh != 0 || m_fl != 0) begin
      e.sh = m_sh[0]; e.fl = m_fl[0]; e.x = 10'(m_x); e.y = 10'(m_y);
      ev_q.push_back(e);
    end
    @(posedge Clk);
    #1;
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 2'b00, 0, '0, '0);
  endtask

  task automatic launch();
    cyc(0, 0, 2'b01, 0, '0, '0);
    cyc(0, 0, 2'b10, 0, '0, '0);
  endtask

  task automatic tick();
    cyc(0, 1, 2'b10, 0, '0, '0);
    cyc(0, 0, 2'b10, 0, '0, '0);
  endtask

  task automatic wait_lfsr(input int target);
    for (int i = 0; i < 300 && lfsr_next(m_lfsr) != target; i++) idle_cyc();
  endtask

  // Monitor: one compare per cycle snapshot, one compare per DUT event pulse.
  always @(negedge Clk) begin
    snap_t s, a;
    ev_t   e, ae;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      a.x = bird_x; a.y = bird_y; a.vis = bird_visible; a.fal = bird_falling;
      a.sh = bird_shot; a.fl = flew_away;
      checks++;
      if (a !== s) begin
        errors++;
        $display("FAIL cycle_outputs: got x=%0d y=%0d vis=%b fal=%b shot=%b flew=%b, expected x=%0d y=%0d vis=%b fal=%b shot=%b flew=%b",
                 a.x, a.y, a.vis, a.fal, a.sh, a.fl, s.x, s.y, s.vis, s.fal, s.sh, s.fl);
      end
    end
    if (bird_shot === 1'b1 || flew_away === 1'b1) begin
      ae.sh = bird_shot; ae.fl = flew_away; ae.x = bird_x; ae.y = bird_y;
      if (flew_away === 1'b1) dut_flew_cnt++;
      $display("event %s at x=%0d y=%0d", bird_shot ? "bird_shot" : "flew_away", bird_x, bird_y);
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got shot=%b flew=%b, expected no event", bird_shot, flew_away);
      end else begin
        e = ev_q.pop_front();
        if (ae !== e) begin
          errors++;
          $display("FAIL event_match: got shot=%b flew=%b x=%0d y=%0d, expected shot=%b flew=%b x=%0d y=%0d",
                   ae.sh, ae.fl, ae.x, ae.y, e.sh, e.fl, e.x, e.y);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit, expected bench completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int flew_before;
    logic [9:0] ax, ay;
    bit tk, sh;
    logic [1:0] st;
    int r;

    // Reset
    cyc(1, 0, 2'b00, 0, '0, '0);
    cyc(1, 0, 2'b00, 0, '0, '0);
    chk("reset_x", int'(bird_x), 64);
    chk("reset_y", int'(bird_y), 400);
    chk("reset_visible", int'(bird_visible), 0);
    chk("reset_pulses", int'(bird_shot) + int'(flew_away), 0);

    // Launch with lfsr A5, then three ticks
    wait_lfsr('hA5);
    launch();
    chk("launch_x", int'(bird_x), 394);
    chk("launch_y", int'(bird_y), 400);
    chk("launch_visible", int'(bird_visible), 1);
    repeat (3) tick();
    chk("fly3_x", int'(bird_x), 400);
    chk("fly3_y", int'(bird_y), 394);

    // Hit at the corner of the window, then fall to ground
    cyc(0, 0, 2'b10, 1, 10'(m_x + 16), 10'(m_y - 16));
    chk("hit_pulse", int'(bird_shot), 1);
    chk("hit_falling", int'(bird_falling), 1);
    cyc(0, 0, 2'b10, 0, '0, '0);
    chk("hit_pulse_end", int'(bird_shot), 0);
    for (int i = 0; i < 50 && m_phase != P_WAIT; i++) tick();
    chk("fall_ground_y", int'(bird_y), 440);
    chk("fall_visible", int'(bird_visible), 0);

    // Near miss, then escape
    launch();
    cyc(0, 0, 2'b10, 1, 10'(m_x + 17), 10'(m_y));
    chk("miss_no_shot", int'(bird_shot), 0);
    flew_before = dut_flew_cnt;
    for (int i = 0; i < 400 && m_phase == P_FLY; i++) tick();
    for (int i = 0; i < 300 && m_phase != P_WAIT; i++) tick();
    chk("escape_one_pulse", dut_flew_cnt - flew_before, 1);
    chk("escape_y", int'(bird_y), 0);
    chk("escape_visible", int'(bird_visible), 0);

    // Right-edge bounce from x=574
    wait_lfsr('hFF);
    launch();
    chk("edge_launch_x", int'(bird_x), 574);
    tick();
    chk("bounce_x", int'(bird_x), 576);
    tick();
    chk("bounce_back_x", int'(bird_x), 574);

    // Hit lands on the cycle the escape condition is live: only bird_shot
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 2'b10, 0, '0, '0);
      if (m_y <= 2) break;
      cyc(0, 0, 2'b10, 0, '0, '0);
    end
    cyc(0, 0, 2'b10, 1, 10'(m_x), 10'(m_y));
    chk("race_shot", int'(bird_shot), 1);
    chk("race_no_flew", int'(flew_away), 0);

    // Relaunch mid-fall, reset mid-fly, done mid-fly
    tick();
    cyc(0, 0, 2'b01, 0, '0, '0);
    chk("relaunch_visible", int'(bird_visible), 0);
    chk("relaunch_falling", int'(bird_falling), 0);
    cyc(0, 0, 2'b10, 0, '0, '0);
    chk("relaunch_fly_visible", int'(bird_visible), 1);
    tick();
    tick();
    cyc(1, 0, 2'b10, 0, '0, '0);
    chk("midfly_reset_x", int'(bird_x), 64);
    chk("midfly_reset_y", int'(bird_y), 400);
    chk("midfly_reset_visible", int'(bird_visible), 0);
    idle_cyc();
    launch();
    tick();
    cyc(0, 0, 2'b11, 0, '0, '0);
    chk("done_visible", int'(bird_visible), 0);

    // Randomized play
    for (int n = 0; n < 3000; n++) begin
      r  = int'($urandom_range(0, 199));
      st = 2'b10;
      if (r == 0) st = 2'b01;
      else if (r == 1) st = 2'b11;
      else if (r == 2) st = 2'b00;
      if ((m_phase == P_IDLE || m_phase == P_WAIT) && $urandom_range(0, 9) == 0) st = 2'b01;
      tk = ($urandom_range(0, 2) == 0);
      sh = !tk && ($urandom_range(0, 5) == 0);
      ax = 10'(m_x + int'($urandom_range(0, 40)) - 20);
      ay = 10'(m_y + int'($urandom_range(0, 40)) - 20);
      cyc(0, tk, st, sh, ax, ay);
    end

    idle_cyc();
    idle_cyc();
    chk("events_drained", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
